stream_unaligner: RTL and testbench

- Decompression-side counterpart of the compression output packer.
- Accepts the packed, byte-dense 256-bit stream (AXI-Stream style: data, keep, last) and keeps a byte-addressed buffer.
- Presents a 272-bit (34-byte) lookahead window to the downstream decoder. The decoder consumes a variable number of bytes per cycle.
- Sits between the input DMA/stream port and the decompression engine.

---
 rtl/stream_unaligner.sv | 111 +++++++++++
 tb/tb_stream_unaligner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_unaligner.sv
// Byte-addressed realignment buffer: packs a keep-masked input stream densely and
// presents a fixed lookahead window that the decoder drains by a variable byte count.
module stream_unaligner #(
   parameter int DATA_IN_WIDTH = 256,
   parameter int WINDOW_WIDTH  = 272,
   parameter int LEN_WIDTH     = 8,
   parameter int BUF_WIDTH     = 576
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_IN_WIDTH-1:0]   s_data,
   input  logic [DATA_IN_WIDTH/8-1:0] s_keep,
   input  logic                       s_valid,
   input  logic                       s_last,
   output logic                       s_ready,
   output logic [WINDOW_WIDTH-1:0]    m_data,
   output logic [LEN_WIDTH-1:0]       m_avail_len,
   output logic                       m_valid,
   output logic                       m_last,
   input  logic                       m_consume_en,
   input  logic [LEN_WIDTH-1:0]       m_consume_len,
   output logic                       err_overconsume
);

   localparam int IN_BYTES  = DATA_IN_WIDTH / 8;
   localparam int WIN_BYTES = WINDOW_WIDTH / 8;
   localparam int BUF_BYTES = BUF_WIDTH / 8;
   localparam int FILL_W    = $clog2(BUF_BYTES + 1);
   localparam int SH_W      = $clog2(BUF_WIDTH + 1);

   localparam logic [FILL_W-1:0] WIN_FILL   = FILL_W'(WIN_BYTES);
   localparam logic [FILL_W-1:0] ACCEPT_MAX = FILL_W'(BUF_BYTES - IN_BYTES);

   logic [BUF_WIDTH-1:0]     byte_buf;
   logic [BUF_WIDTH-1:0]     buf_next;
   logic [FILL_W-1:0]        fill;
   logic [FILL_W-1:0]        fill_next;
   logic [FILL_W-1:0]        kept;
   logic [FILL_W-1:0]        avail;
   logic [FILL_W-1:0]        cons_bytes;
   logic [FILL_W-1:0]        in_bytes;
   logic [DATA_IN_WIDTH-1:0] in_masked;
   logic [SH_W-1:0]          sh_out;
   logic [SH_W-1:0]          sh_in;
   logic                     eos;
   logic                     eos_next;
   logic                     err_q;
   logic                     accept;
   logic                     consume_req;
   logic                     consume_ok;
   logic                     consume_bad;

   // Ready depends on registered state only, so upstream may wait on it before raising valid.
   assign s_ready     = !eos && (fill <= ACCEPT_MAX);
   assign avail       = (fill >= WIN_FILL) ? WIN_FILL : fill;
   assign m_avail_len = LEN_WIDTH'(avail);
   assign m_valid     = (fill >= WIN_FILL) || (eos && (fill != '0));
   assign m_last      = eos && (fill <= WIN_FILL);
   // Bytes above fill are held at zero, so the low window slice needs no extra masking.
   assign m_data          = byte_buf[WINDOW_WIDTH-1:0];
   assign err_overconsume = err_q;

   assign accept      = s_valid && s_ready;
   assign consume_req = m_consume_en && m_valid;
   assign consume_ok  = consume_req && (m_consume_len != '0) && (m_consume_len <= m_avail_len);
   assign consume_bad = consume_req && !consume_ok;

   always_comb begin
      in_masked = '0;
      in_bytes  = '0;
      for (int i = 0; i < IN_BYTES; i++) begin
         if (s_keep[i]) begin
            in_masked[8*i +: 8] = s_data[8*i +: 8];
            in_bytes            = in_bytes + FILL_W'(1);
         end
      end
   end

   always_comb begin
      cons_bytes = consume_ok ? FILL_W'(m_consume_len) : '0;
      kept       = fill - cons_bytes;
      fill_next  = kept + (accept ? in_bytes : '0);
      sh_out     = SH_W'({cons_bytes, 3'b000});
      sh_in      = SH_W'({kept, 3'b000});
      buf_next   = (byte_buf >> sh_out)
                 | (accept ? (BUF_WIDTH'(in_masked) << sh_in) : '0);
      // An empty final word on an empty buffer never opens a stream.
      if (accept && s_last) begin
         eos_next = (fill_next != '0);
      end else if (eos && (fill_next == '0)) begin
         eos_next = 1'b0;
      end else begin
         eos_next = eos;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_buf <= '0;
         fill     <= '0;
         eos      <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         byte_buf <= buf_next;
         fill     <= fill_next;
         eos      <= eos_next;
         err_q    <= err_q | consume_bad;
      end
   end

endmodule

// File: tb/tb_stream_unaligner.sv
// Randomized bench for stream_unaligner against a byte-queue reference model,
// with directed sequences covering fill limits, drain, short words, errors and reset.
module tb_stream_unaligner;

   logic         clk = 1'b0;
   logic         reset;
   logic [255:0] s_data;
   logic [31:0]  s_keep;
   logic         s_valid;
   logic         s_last;
   logic         s_ready;
   logic [271:0] m_data;
   logic [7:0]   m_avail_len;
   logic         m_valid;
   logic         m_last;
   logic         m_consume_en;
   logic [7:0]   m_consume_len;
   logic         err_overconsume;

   stream_unaligner dut (
      .clk             (clk),
      .reset           (reset),
      .s_data          (s_data),
      .s_keep          (s_keep),
      .s_valid         (s_valid),
      .s_last          (s_last),
      .s_ready         (s_ready),
      .m_data          (m_data),
      .m_avail_len     (m_avail_len),
      .m_valid         (m_valid),
      .m_last          (m_last),
      .m_consume_en    (m_consume_en),
      .m_consume_len   (m_consume_len),
      .err_overconsume (err_overconsume)
   );

   always #5 clk = ~clk;

   byte unsigned mq[$];
   bit           meos;
   bit           merr;
   bit           acc_flag;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_avail();
      return (mq.size() > 34) ? 34 : mq.size();
   endfunction

   function automatic bit model_valid();
      return (mq.size() >= 34) || (meos && mq.size() > 0);
   endfunction

   // Compare outputs against the model at the falling edge, then advance the model
   // with the inputs presented for the coming rising edge.
   task automatic step();
      int           av;
      int           nin;
      bit           v;
      bit           l;
      bit           r;
      logic [271:0] w;
      @(negedge clk);
      av = model_avail();
      v  = model_valid();
      l  = meos && (mq.size() <= 34);
      r  = !meos && (mq.size() <= 40);
      w  = '0;
      for (int i = 0; i < av; i++) w[i*8 +: 8] = mq[i];
      check("s_ready", s_ready, r);
      check("m_valid", m_valid, v);
      check("m_last", m_last, l);
      check("m_avail_len", m_avail_len, av);
      check("m_data", m_data, w);
      check("err_overconsume", err_overconsume, merr);
      acc_flag = 1'b0;
      if (reset) begin
         mq.delete();
         meos = 1'b0;
         merr = 1'b0;
      end else begin
         if (m_consume_en && v) begin
            if (m_consume_len >= 1 && int'(m_consume_len) <= av) begin
               repeat (int'(m_consume_len)) void'(mq.pop_front());
            end else begin
               merr = 1'b1;
            end
         end
         if (s_valid && r) begin
            acc_flag = 1'b1;
            nin = $countones(s_keep);
            for (int i = 0; i < nin; i++) mq.push_back(s_data[i*8 +: 8]);
         end
         if (acc_flag && s_last) meos = (mq.size() != 0);
         else if (meos && mq.size() == 0) meos = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_word(input int k, input bit last);
      for (int i = 0; i < 8; i++) s_data[i*32 +: 32] = $urandom();
      s_keep = '0;
      for (int i = 0; i < k; i++) s_keep[i] = 1'b1;
      s_last = last;
   endtask

   task automatic consume(input int len);
      m_consume_en  = 1'b1;
      m_consume_len = 8'(len);
   endtask

   initial begin
      bit pend;
      int words_left;
      int av;
      int rr;

      reset = 1'b1;
      s_data = '0; s_keep = '0; s_valid = 1'b0; s_last = 1'b0;
      m_consume_en = 1'b0; m_consume_len = '0;
      repeat (2) @(posedge clk);
      #1;
      step();
      reset = 1'b0;

      // two full words, no consume
      s_valid = 1'b1;
      set_word(32, 1'b0); step();
      set_word(32, 1'b1); step();
      s_valid = 1'b0;
      step();
      check("tp1_avail", m_avail_len, 34);
      check("tp1_valid", m_valid, 1);
      check("tp1_last", m_last, 0);

      // drain 10 bytes per cycle
      for (int k = 0; k < 20 && model_valid(); k++) begin
         av = model_avail();
         consume(av < 10 ? av : 10);
         step();
      end
      m_consume_en = 1'b0;
      step();
      check("tp2_valid_off", m_valid, 0);
      check("tp2_ready", s_ready, 1);

      // fill to 66, held word, then consume opens room
      s_valid = 1'b1;
      set_word(32, 1'b0); step();
      set_word(32, 1'b0); step();
      s_valid = 1'b0;
      consume(30); step();
      m_consume_en = 1'b0;
      s_valid = 1'b1;
      set_word(32, 1'b0); step();
      set_word(32, 1'b0); step(); step();
      check("tp3_held", s_ready, 0);
      consume(30); step();
      m_consume_en = 1'b0;
      step();
      s_valid = 1'b0;
      step();
      check("tp3_avail", m_avail_len, 34);
      reset = 1'b1; step(); reset = 1'b0;

      // single short last word
      s_valid = 1'b1;
      set_word(8, 1'b1); step();
      s_valid = 1'b0;
      check("tp4_last", m_last, 1);
      check("tp4_avail", m_avail_len, 8);
      check("tp4_upper", m_data[271:64], 0);
      consume(8); step();
      m_consume_en = 1'b0;
      check("tp4_empty", m_valid, 0);

      // over-consume, then simultaneous accept and consume at fill 40
      s_valid = 1'b1;
      set_word(8, 1'b1); step();
      s_valid = 1'b0;
      consume(20); step();
      check("tp5_err", err_overconsume, 1);
      check("tp5_avail", m_avail_len, 8);
      m_consume_en = 1'b0; step();
      check("tp5_err_sticky", err_overconsume, 1);
      consume(8); step();
      m_consume_en = 1'b0;
      s_valid = 1'b1;
      set_word(32, 1'b0); step();
      set_word(32, 1'b0); step();
      s_valid = 1'b0;
      consume(24); step();
      s_valid = 1'b1;
      set_word(32, 1'b0);
      consume(34); step();
      m_consume_en = 1'b0;

      // reset with fill 50 and eos set
      set_word(12, 1'b1); step();
      s_valid = 1'b0;
      check("tp6_not_ready", s_ready, 0);
      check("tp6_last_off", m_last, 0);
      reset = 1'b1; step(); reset = 1'b0;
      check("tp6_valid", m_valid, 0);
      check("tp6_ready", s_ready, 1);
      check("tp6_err", err_overconsume, 0);
      check("tp6_avail", m_avail_len, 0);

      // randomized traffic
      pend = 1'b0;
      words_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!pend && ($urandom % 4 != 0)) begin
            if (words_left == 0) words_left = $urandom_range(1, 4);
            words_left--;
            if (words_left == 0) set_word($urandom_range(0, 32), 1'b1);
            else set_word(32, 1'b0);
            pend = 1'b1;
         end
         s_valid = pend && ($urandom % 10 < 7);
         av = model_avail();
         m_consume_en = ($urandom % 10 < 6);
         rr = $urandom % 50;
         if (rr == 0) m_consume_len = 8'd0;
         else if (rr == 1) m_consume_len = 8'(av + 1);
         else m_consume_len = (av > 0) ? 8'($urandom_range(1, av)) : 8'd1;
         reset = ($urandom % 500 == 0);
         step();
         if (acc_flag) pend = 1'b0;
         if (reset) begin
            pend = 1'b0;
            words_left = 0;
            reset = 1'b0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
